approx_dot_accum: RTL and testbench
===================================

APPROX_DOT_ACCUM -- requirements
Module: approx_dot_accum

Interface
REQ-001 Parameter ACC_W, default 24: accumulator and result width in bits; minimum 16.
REQ-002 Parameter CNT_W, default 8: term-counter width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  product beat valid.
REQ-006 in_ready  output  1  block can accept a product beat.
REQ-007 in_prod  input  16  unsigned product from the upstream 8x8 approximate multiplier.
REQ-008 in_last  input  1  marks the final term of the current dot-product vector.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_sum  output  ACC_W  unsigned accumulated sum of the vector.
REQ-012 out_count  output  CNT_W  number of terms accepted in the vector.
REQ-013 out_sat  output  1  sum saturated during the vector.

Function
REQ-014 The block SHALL implement a two-state FSM: ACC (accepting terms) and HOLD (presenting the result).
REQ-015 in_ready SHALL be 1 in ACC and 0 in HOLD; out_valid SHALL be 1 in HOLD and 0 in ACC.
REQ-016 A beat is accepted only on a clock edge where in_valid=1 and in_ready=1; cycles with in_valid=0 SHALL leave all state unchanged.
REQ-017 On acceptance, acc SHALL become acc + in_prod, with in_prod zero-extended to ACC_W+1 bits before the add.
REQ-018 If the sum exceeds 2^ACC_W-1, acc SHALL clamp to 2^ACC_W-1 and the sticky sat flag SHALL be set; once set, sat stays 1 and acc stays clamped until the vector is cleared.
REQ-019 On acceptance, cnt SHALL increment by 1 and saturate at 2^CNT_W-1, never wrapping; a saturated count does not set sat.
REQ-020 Acceptance with in_last=1 SHALL fold that beat into acc, cnt and sat, then move the FSM to HOLD on the same edge.
REQ-021 Latency: out_valid SHALL rise in the cycle immediately after the edge that accepts the last beat.
REQ-022 In HOLD, out_sum, out_count and out_sat SHALL be driven directly from acc, cnt and sat and SHALL stay stable while out_ready=0.
REQ-023 In HOLD, an edge with out_ready=1 SHALL clear acc, cnt and sat to 0 and return the FSM to ACC.
REQ-024 Throughput: there is at most one vector in flight. The first beat of the next vector is accepted no earlier than the cycle after the result handshake, so there is at least one idle input cycle per vector.
REQ-025 In ACC, the outputs out_sum, out_count and out_sat SHALL show the running values. Consumers qualify them only with out_valid.
REQ-026 A single-beat vector (in_last=1 on the first beat) SHALL be legal and SHALL give out_count=1.
REQ-027 The datapath SHALL be fully synchronous, with no combinational path from in_valid or out_ready to in_ready or out_valid.

Reset
REQ-028 While rst_n=0, the block SHALL force FSM=ACC and acc=0, cnt=0, sat=0.
REQ-029 During reset the outputs SHALL be in_ready=1, out_valid=0, out_sum=0, out_count=0, out_sat=0.
REQ-030 Reset asserted mid-vector or in HOLD SHALL discard the partial or held result, with no output handshake.
REQ-031 The first beat SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-032 Three beats 100, 200, 300 with last on the third, out_ready=1 -> one cycle later out_valid=1, out_sum=600, out_count=3, out_sat=0; next cycle out_valid=0 and in_ready=1.
REQ-033 Single beat in_prod=0 with in_last=1 -> out_sum=0, out_count=1, out_sat=0.
REQ-034 257 beats of 0xFFFF with last on the final beat -> out_sum=16777215, out_count=255, out_sat=1.
REQ-035 Result of 5+7=12 with out_ready held at 0 for 5 cycles -> out_valid=1, out_sum=12 stable for all 5 cycles, in_ready=0, in_valid beats ignored; release -> clean return to ACC.
REQ-036 Beats 10 and 20 with random in_valid gaps -> out_sum=30, out_count=2.
REQ-037 Two beats accepted, then rst_n pulsed low asynchronously -> all outputs 0 immediately; new vector {1} with last -> out_sum=1, out_count=1.

Source files
------------

// File: rtl/approx_dot_accum.sv
// approx_dot_accum
//   Accumulates a vector of unsigned 16-bit products from an upstream
//   approximate multiplier into a saturating sum. It also counts the terms
//   and flags any saturation. The result is held until downstream takes it.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : product beat valid
//   in_ready   : block can accept a beat (ACC state)
//   in_prod    : 16-bit unsigned product
//   in_last    : final term of the current vector
//   out_valid  : result valid (HOLD state)
//   out_ready  : downstream accepts the result
//   out_sum    : accumulated sum (running value while accumulating)
//   out_count  : number of terms accepted, saturating
//   out_sat    : sum clamped at some point during the vector
module approx_dot_accum #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic {
        ACC,
        HOLD
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sat, sat_nxt;
    logic [ACC_W:0]   sum_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            sat   <= sat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        sat_nxt   = sat;
        // Handshake flags depend on registered state only, so there is no
        // combinational path from in_valid/out_ready to them.
        in_ready  = (state == ACC);
        out_valid = (state == HOLD);
        // One extra bit catches the carry out of the accumulator.
        sum_ext   = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, in_prod};

        case (state)
            ACC: begin
                if (in_valid) begin
                    if (sat || sum_ext[ACC_W]) begin
                        acc_nxt = '1;
                        sat_nxt = 1'b1;
                    end else begin
                        acc_nxt = sum_ext[ACC_W-1:0];
                    end
                    if (cnt != '1) begin
                        cnt_nxt = cnt + {{(CNT_W - 1){1'b0}}, 1'b1};
                    end
                    if (in_last) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    sat_nxt   = 1'b0;
                    state_nxt = ACC;
                end
            end
            default: begin
                state_nxt = ACC;
            end
        endcase
    end

    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_sat   = sat;

endmodule

// File: tb/tb_approx_dot_accum.sv
module tb_approx_dot_accum;

    localparam int ACC_W = 24;
    localparam int CNT_W = 8;
    localparam longint SUM_MAX = (64'd1 << ACC_W) - 1;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    approx_dot_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    // Beats of the vector to be sent next, and the captured result.
    logic [15:0]      beats[$];
    logic [ACC_W-1:0] got_sum;
    logic [CNT_W-1:0] got_cnt;
    logic             got_sat;

    // Sends the queued vector with optional idle gaps. Holds the result for
    // hold_cycles while stray beats are offered, then completes the handshake.
    task automatic run_vector(input int gap_max, input int hold_cycles);
        int n;
        n = beats.size();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                in_prod  = 16'($urandom);
                in_last  = 1'($urandom);
                @(posedge clk); #1;
            end
            chk("in_ready_acc", in_ready, 1);
            in_valid = 1'b1;
            in_prod  = beats[i];
            in_last  = (i == n - 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        chk("out_valid_rise", out_valid, 1);
        got_sum = out_sum;
        got_cnt = out_count;
        got_sat = out_sat;
        for (int h = 0; h < hold_cycles; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_prod   = 16'($urandom);
            in_last   = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_sum_stable", out_sum, got_sum);
            chk("hold_cnt_stable", out_count, got_cnt);
            chk("hold_sat_stable", out_sat, got_sat);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        chk("release_sum_clr", out_sum, 0);
        chk("release_cnt_clr", out_count, 0);
        chk("release_sat_clr", out_sat, 0);
    endtask

    typedef struct {
        int               n;
        logic [3:0][15:0] b;
        longint           exp_sum;
        longint           exp_cnt;
        bit               exp_sat;
    } vec_t;

    vec_t tbl[5];

    initial begin
        longint total;
        int     len;
        bit     big;

        tbl[0].n = 3; tbl[0].b = {16'd0, 16'd300, 16'd200, 16'd100};
        tbl[0].exp_sum = 600; tbl[0].exp_cnt = 3; tbl[0].exp_sat = 0;
        tbl[1].n = 1; tbl[1].b = '0;
        tbl[1].exp_sum = 0; tbl[1].exp_cnt = 1; tbl[1].exp_sat = 0;
        tbl[2].n = 2; tbl[2].b = {16'd0, 16'd0, 16'd7, 16'd5};
        tbl[2].exp_sum = 12; tbl[2].exp_cnt = 2; tbl[2].exp_sat = 0;
        tbl[3].n = 4; tbl[3].b = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[3].exp_sum = 262140; tbl[3].exp_cnt = 4; tbl[3].exp_sat = 0;
        tbl[4].n = 1; tbl[4].b = {16'd0, 16'd0, 16'd0, 16'd40000};
        tbl[4].exp_sum = 40000; tbl[4].exp_cnt = 1; tbl[4].exp_sat = 0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_count", out_count, 0);
        chk("rst_sat", out_sat, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table vectors; the first starts on the first edge after reset.
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            beats.delete();
            for (int k = 0; k < tbl[t].n; k++) beats.push_back(tbl[t].b[k]);
            run_vector(0, 0);
            chk("tbl_sum", got_sum, tbl[t].exp_sum);
            chk("tbl_count", got_cnt, tbl[t].exp_cnt);
            chk("tbl_sat", got_sat, tbl[t].exp_sat);
        end

        // Result held with out_ready low for 5 cycles while beats are offered.
        beats.delete();
        beats.push_back(16'd5);
        beats.push_back(16'd7);
        run_vector(0, 5);
        chk("hold_sum", got_sum, 12);
        chk("hold_count", got_cnt, 2);

        // Beats separated by random idle gaps.
        beats.delete();
        beats.push_back(16'd10);
        beats.push_back(16'd20);
        run_vector(4, 0);
        chk("gap_sum", got_sum, 30);
        chk("gap_count", got_cnt, 2);

        // Saturation of both the sum and the count.
        beats.delete();
        repeat (257) beats.push_back(16'hFFFF);
        run_vector(0, 0);
        chk("sat_sum", got_sum, 16777215);
        chk("sat_count", got_cnt, 255);
        chk("sat_flag", got_sat, 1);

        // Asynchronous reset in the middle of a vector.
        in_valid = 1'b1; in_prod = 16'd3; in_last = 1'b0;
        @(posedge clk); #1;
        in_prod = 16'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_running_sum", out_sum, 7);
        chk("mid_running_cnt", out_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sum", out_sum, 0);
        chk("arst_count", out_count, 0);
        chk("arst_sat", out_sat, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        beats.delete();
        beats.push_back(16'd1);
        run_vector(0, 0);
        chk("post_rst_sum", got_sum, 1);
        chk("post_rst_count", got_cnt, 1);

        // Random vectors against a whole-vector arithmetic model: the sum is
        // the exact total clamped at the end, the count is the length clamped.
        for (int v = 0; v < 20; v++) begin
            big = (v % 5 == 4);
            len = big ? $urandom_range(250, 300) : $urandom_range(1, 8);
            beats.delete();
            total = 0;
            for (int k = 0; k < len; k++) begin
                logic [15:0] p;
                p = big ? 16'($urandom_range(16'hF000, 16'hFFFF)) : 16'($urandom);
                beats.push_back(p);
                total += p;
            end
            run_vector(big ? 0 : 2, $urandom_range(0, 3));
            chk("rnd_sum", got_sum, (total > SUM_MAX) ? SUM_MAX : total);
            chk("rnd_count", got_cnt, (len > CNT_MAX) ? CNT_MAX : len);
            chk("rnd_sat", got_sat, (total > SUM_MAX) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
